adffe_shift_ift: RTL and testbench

//  Taint-instrumented (IFT) parametrised shift register: DEPTH stages of WIDTH bits, clock enable,

---
 rtl/adffe_shift_ift.sv | 118 +++++++++++
 tb/tb_adffe_shift_ift.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adffe_shift_ift.sv
// adffe_shift_ift: taint-tracking enabled shift register, async active-low reset.
// Optional IFT_XCLR_EN: unknown stage input data clears that stage's taint.
module adffe_shift_ift #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 4,
  parameter int               TAINT_W    = 32,
  parameter logic [WIDTH-1:0] ARST_VALUE = '0
) (
  input  logic               CLK,
  input  logic [TAINT_W-1:0] CLK_t,
  input  logic               ARST_N,
  input  logic [TAINT_W-1:0] ARST_N_t,
  input  logic               EN,
  input  logic [TAINT_W-1:0] EN_t,
  input  logic [WIDTH-1:0]   D,
  input  logic [TAINT_W-1:0] D_t,
  output logic [WIDTH-1:0]   Q,
  output logic [TAINT_W-1:0] Q_t,
  output logic               FULL,
  output logic [TAINT_W-1:0] FULL_t
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

`ifdef IFT_XCLR_EN
  localparam bit XCLR = 1'b1;
`else
  localparam bit XCLR = 1'b0;
`endif

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [TAINT_W-1:0] tw_t;

  word_t          s_q    [DEPTH];
  tw_t            t_q    [DEPTH];
  logic [CW-1:0]  cnt_q;
  tw_t            full_t_q;

  word_t          in_v   [DEPTH];
  tw_t            in_t   [DEPTH];
  tw_t            rst_t  [DEPTH];
  tw_t            run_t  [DEPTH];
  tw_t            hold_t [DEPTH];

  // Clock taint does not flow into any state.
  logic unused_clk_t;
  assign unused_clk_t = ^CLK_t;

  // Stage inputs: D feeds stage 0, each later stage reads its predecessor.
  always_comb begin
    in_v[0] = D;
    in_t[0] = D_t;
    for (int i = 1; i < DEPTH; i++) begin
      in_v[i] = s_q[i-1];
      in_t[i] = t_q[i-1];
    end
  end

  // Next-taint candidates for reset, enabled shift and blocked hold.
  // An unknown comparison takes the else arm, i.e. counts as false.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rst_t[i]  = ARST_N_t;
      run_t[i]  = in_t[i];
      hold_t[i] = t_q[i];
      if (in_v[i] == ARST_VALUE) begin
        rst_t[i] = in_t[i] | ARST_N_t;
        run_t[i] = run_t[i] | ARST_N_t;
      end
      if (in_v[i] != s_q[i]) begin
        run_t[i]  = run_t[i] | EN_t;
        hold_t[i] = hold_t[i] | EN_t;
      end
      if (XCLR && ((^in_v[i]) === 1'bx)) begin
        rst_t[i]  = '0;
        run_t[i]  = '0;
        hold_t[i] = '0;
      end
    end
  end

  // Stage values and taints; reset re-evaluates on every edge while held.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= ARST_VALUE;
        t_q[i] <= rst_t[i];
      end
    end else if (EN) begin
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= in_v[i];
        t_q[i] <= run_t[i];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        t_q[i] <= hold_t[i];
      end
    end
  end

  // Saturating fill counter and its taint.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      cnt_q    <= '0;
      full_t_q <= ARST_N_t;
    end else if (EN && (cnt_q < CNT_MAX)) begin
      cnt_q    <= cnt_q + CW'(1);
      full_t_q <= full_t_q | EN_t;
    end
  end

  assign Q      = s_q[DEPTH-1];
  assign Q_t    = t_q[DEPTH-1];
  assign FULL   = (cnt_q == CNT_MAX);
  assign FULL_t = full_t_q;

endmodule

// File: tb/tb_adffe_shift_ift.sv
// tb_adffe_shift_ift: directed and random checks of adffe_shift_ift
// against an array-based reference model of the stage rules.
module tb_adffe_shift_ift;

  localparam int W  = 8;
  localparam int DP = 4;
  localparam int TW = 32;
  localparam logic [W-1:0] AV = 8'h00;

`ifdef IFT_XCLR_EN
  localparam bit XCLR = 1'b1;
`else
  localparam bit XCLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          en = 1'b0;
  logic [TW-1:0] clk_t = '0;
  logic [TW-1:0] arst_n_t = '0;
  logic [TW-1:0] en_t = '0;
  logic [W-1:0]  d = '0;
  logic [TW-1:0] d_t = '0;
  logic [W-1:0]  q;
  logic [TW-1:0] q_t;
  logic          full;
  logic [TW-1:0] full_t;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  adffe_shift_ift #(
    .WIDTH(W), .DEPTH(DP), .TAINT_W(TW), .ARST_VALUE(AV)
  ) dut (
    .CLK(clk), .CLK_t(clk_t),
    .ARST_N(arst_n), .ARST_N_t(arst_n_t),
    .EN(en), .EN_t(en_t),
    .D(d), .D_t(d_t),
    .Q(q), .Q_t(q_t),
    .FULL(full), .FULL_t(full_t)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0]  ms [DP];
  logic [TW-1:0] mt [DP];
  int            mcnt = 0;
  logic [TW-1:0] mft = '0;

  initial begin
    for (int i = 0; i < DP; i++) begin
      ms[i] = '0;
      mt[i] = '0;
    end
  end

  function automatic bit is_eq(logic [W-1:0] a, logic [W-1:0] b);
    return ((a == b) === 1'b1);
  endfunction

  function automatic bit is_ne(logic [W-1:0] a, logic [W-1:0] b);
    return ((a != b) === 1'b1);
  endfunction

  function automatic bit is_x(logic [W-1:0] a);
    return XCLR && ($isunknown(a));
  endfunction

  task automatic m_reset();
    logic [W-1:0]  iv [DP];
    logic [TW-1:0] it [DP];
    logic [TW-1:0] nt [DP];
    for (int i = 0; i < DP; i++) begin
      if (i == 0) begin iv[i] = d; it[i] = d_t; end
      else begin iv[i] = ms[i-1]; it[i] = mt[i-1]; end
      nt[i] = is_eq(iv[i], AV) ? (it[i] | arst_n_t) : arst_n_t;
      if (is_x(iv[i])) nt[i] = '0;
    end
    for (int i = 0; i < DP; i++) begin
      ms[i] = AV;
      mt[i] = nt[i];
    end
    mcnt = 0;
    mft  = arst_n_t;
  endtask

  task automatic m_clock();
    logic [W-1:0]  iv [DP];
    logic [TW-1:0] it [DP];
    logic [TW-1:0] nt [DP];
    for (int i = 0; i < DP; i++) begin
      if (i == 0) begin iv[i] = d; it[i] = d_t; end
      else begin iv[i] = ms[i-1]; it[i] = mt[i-1]; end
      if (en) begin
        nt[i] = it[i];
        if (is_eq(iv[i], AV)) nt[i] |= arst_n_t;
      end else begin
        nt[i] = mt[i];
      end
      if (is_ne(iv[i], ms[i])) nt[i] |= en_t;
      if (is_x(iv[i])) nt[i] = '0;
    end
    for (int i = 0; i < DP; i++) begin
      if (en) ms[i] = iv[i];
      mt[i] = nt[i];
    end
    if (en && mcnt < DP) begin
      mcnt = mcnt + 1;
      mft  = mft | en_t;
    end
  endtask

  always @(negedge arst_n) m_reset();

  always @(posedge clk) begin
    if (!arst_n) m_reset();
    else m_clock();
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("m_q", 32'(q), 32'(ms[DP-1]));
      check("m_qt", q_t, mt[DP-1]);
      check("m_full", 32'(full), 32'(mcnt == DP));
      check("m_fullt", full_t, mft);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] rnd_taint();
    if ($urandom_range(0, 1) == 0) return '0;
    return TW'(1) << $urandom_range(0, TW - 1);
  endfunction

  logic [W-1:0]  xv;
  logic [TW-1:0] xexp;
  int            rcnt;

  initial begin
    // Reset with tainted data and reset
    #1;
    arst_n_t = 32'd2;
    d   = 8'h00;
    d_t = 32'd1;
    #1 arst_n = 1'b0;
    repeat (5) step();
    chk_on = 1'b1;
    check("t1_q", 32'(q), 32'h0);
    check("t1_qt", q_t, 32'd3);
    check("t1_full", 32'(full), 32'd0);
    check("t1_fullt", full_t, 32'd2);

    // Release and push A5 through
    arst_n = 1'b1;
    en   = 1'b1;
    en_t = '0;
    d    = 8'hA5;
    d_t  = 32'd4;
    step();
    d   = 8'h00;
    d_t = '0;
    step();
    step();
    check("t2_q_e3", 32'(q), 32'h0);
    check("t2_full_e3", 32'(full), 32'd0);
    step();
    check("t2_q_e4", 32'(q), 32'hA5);
    check("t2_qt_e4", q_t, 32'd4);
    check("t2_full_e4", 32'(full), 32'd1);
    step();
    check("t2_q_e5", 32'(q), 32'h0);
    check("t2_full_e5", 32'(full), 32'd1);

    // Load 4,3,2,1 then a blocked hold
    for (int k = 1; k <= 4; k++) begin
      d = W'(k);
      step();
    end
    en   = 1'b0;
    en_t = 32'd8;
    d    = 8'h3C;
    step();
    check("t3_q_hold", 32'(q), 32'h1);
    check("t3_qt_b3", q_t & 32'd8, 32'd8);
    check("t3_full", 32'(full), 32'd1);

    // Reset between edges
    @(negedge clk);
    arst_n_t = 32'd16;
    #1 arst_n = 1'b0;
    #1;
    check("t4_q", 32'(q), 32'(AV));
    check("t4_full", 32'(full), 32'd0);
    check("t4_fullt", full_t, 32'd16);
    step();
    step();
    arst_n   = 1'b1;
    arst_n_t = '0;
    en_t     = '0;
    d_t      = '0;

    // Alternating enable, incrementing data
    for (int k = 0; k < 8; k++) begin
      d  = W'(8'h10 + k);
      en = (k % 2 == 0);
      step();
      if (k == 5) check("t5_full_3en", 32'(full), 32'd0);
      if (k == 6) begin
        check("t5_q_4en", 32'(q), 32'h10);
        check("t5_full_4en", 32'(full), 32'd1);
      end
    end

    // Unknown data with taint
    xv   = 'x;
    xexp = (XCLR && $isunknown(xv)) ? 32'h0 : 32'hFF;
    en   = 1'b1;
    d    = xv;
    d_t  = 32'hFF;
    step();
    d   = 8'h00;
    d_t = '0;
    repeat (3) step();
    check("t6_xtaint", q_t & 32'hFF, xexp);

    // Random traffic with occasional async resets
    rcnt = 0;
    for (int n = 0; n < 400; n++) begin
      en       = ($urandom_range(0, 9) < 7);
      en_t     = rnd_taint();
      d_t      = rnd_taint();
      arst_n_t = rnd_taint();
      case ($urandom_range(0, 3))
        0:       d = AV;
        1:       d = ms[0];
        default: d = W'($urandom);
      endcase
      if (!arst_n) begin
        rcnt--;
        if (rcnt <= 0) arst_n = 1'b1;
        step();
      end else if ($urandom_range(0, 39) == 0) begin
        rcnt = $urandom_range(1, 3);
        #2 arst_n = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        step();
      end
    end
    arst_n = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
